// File: rtl/lane_scan_ctrl.sv
// Job sequencer for the 64-lane encoder datapath: LOAD, NUM_ROUNDS scan rounds, OUT, DONE.
// Optional abort input is compiled in when ROUND_CTRL_ABORT_EN is defined.
module lane_scan_ctrl #(
    parameter int NUM_ROUNDS = 24,
    parameter int RND_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef ROUND_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    output logic             lane_wr_en,
    input  logic             cnt_co,
    output logic             counter_rst,
    output logic             inc_counter,
    input  logic             stall,
    output logic             stage_en,
    output logic [RND_W-1:0] round_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [RND_W-1:0] round_r;
    logic [RND_W-1:0] round_nxt_s;

    // State and round-number registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            round_r <= {RND_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            round_r <= round_nxt_s;
        end
    end

    // Next-state, round advance and handshake/counter control decode.
    always_comb begin
        state_nxt_s = state_r;
        round_nxt_s = round_r;
        in_ready    = 1'b0;
        lane_wr_en  = 1'b0;
        counter_rst = 1'b0;
        inc_counter = 1'b0;
        stage_en    = 1'b0;
        out_valid   = 1'b0;
        done        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                counter_rst = 1'b1;
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    lane_wr_en  = 1'b1;
                    inc_counter = 1'b1;
                    if (cnt_co) begin
                        counter_rst = 1'b1;
                        state_nxt_s = ST_ROUND;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_ROUND: begin
                if (!stall) begin
                    stage_en    = 1'b1;
                    inc_counter = 1'b1;
                    if (cnt_co) begin
                        counter_rst = 1'b1;
                        // Final lane of a round: advance the round or leave for OUT.
                        if (round_r == LAST_RND) begin
                            round_nxt_s = {RND_W{1'b0}};
                            state_nxt_s = ST_OUT;
                        end else begin
                            round_nxt_s = round_r + RND_W'(1);
                            state_nxt_s = ST_ROUND;
                        end
                    end else begin
                        state_nxt_s = ST_ROUND;
                    end
                end else begin
                    state_nxt_s = ST_ROUND;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    inc_counter = 1'b1;
                    if (cnt_co) begin
                        counter_rst = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_OUT;
                    end
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                counter_rst = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                counter_rst = 1'b1;
                state_nxt_s = ST_IDLE;
                round_nxt_s = {RND_W{1'b0}};
            end
        endcase

`ifdef ROUND_CTRL_ABORT_EN
        // Abort overrides every transition of an active job and suppresses completion.
        if (abort && (state_r != ST_IDLE)) begin
            state_nxt_s = ST_IDLE;
            round_nxt_s = {RND_W{1'b0}};
            counter_rst = 1'b1;
            inc_counter = 1'b0;
            done        = 1'b0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
`endif
    end

    assign round_idx = round_r;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_lane_scan_ctrl.sv
// Bench for lane_scan_ctrl: external 6-bit lane counter, progress-count reference model,
// per-cycle output comparison and directed job scenarios with literal latencies.
module tb_lane_scan_ctrl;

    localparam int NR    = 2;
    localparam int RND_W = 5;
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_ROUND = 2, PH_OUT = 3, PH_DONE = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             lane_wr_en;
    logic             cnt_co;
    logic             counter_rst;
    logic             inc_counter;
    logic             stall = 1'b0;
    logic             stage_en;
    logic [RND_W-1:0] round_idx;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             done;

    logic [5:0] cnt = 6'd0;
    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: job progress expressed as lane counts per phase.
    logic m_active = 1'b0;
    int   m_loaded = 0;
    int   m_steps  = 0;
    int   m_sent   = 0;

    lane_scan_ctrl #(.NUM_ROUNDS(NR), .RND_W(RND_W)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef ROUND_CTRL_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .lane_wr_en(lane_wr_en),
        .cnt_co(cnt_co), .counter_rst(counter_rst), .inc_counter(inc_counter),
        .stall(stall), .stage_en(stage_en), .round_idx(round_idx),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // External lane counter: clear has priority over increment.
    always @(posedge clk or negedge rst) begin
        if (!rst)             cnt <= 6'd0;
        else if (counter_rst) cnt <= 6'd0;
        else if (inc_counter) cnt <= cnt + 6'd1;
    end
    assign cnt_co = (cnt == 6'd63);

    function automatic int m_phase();
        if (!m_active)           return PH_IDLE;
        if (m_loaded < 64)       return PH_LOAD;
        if (m_steps < 64 * NR)   return PH_ROUND;
        if (m_sent < 64)         return PH_OUT;
        return PH_DONE;
    endfunction

    function automatic logic abort_hit();
`ifdef ROUND_CTRL_ABORT_EN
        return abort && (m_phase() != PH_IDLE);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_loaded <= 0;
            m_steps  <= 0;
            m_sent   <= 0;
        end else if (abort_hit()) begin
            m_active <= 1'b0;
        end else begin
            case (m_phase())
                PH_IDLE:  if (start) begin
                              m_active <= 1'b1;
                              m_loaded <= 0;
                              m_steps  <= 0;
                              m_sent   <= 0;
                          end
                PH_LOAD:  if (in_valid)  m_loaded <= m_loaded + 1;
                PH_ROUND: if (!stall)    m_steps  <= m_steps + 1;
                PH_OUT:   if (out_ready) m_sent   <= m_sent + 1;
                default:  m_active <= 1'b0;
            endcase
        end
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        int   ph;
        logic e_rdy, e_wr, e_crst, e_inc, e_stg, e_ov, e_done;
        int   e_rnd, e_cnt;
        ph = m_phase();
        e_rdy = 0; e_wr = 0; e_crst = 0; e_inc = 0; e_stg = 0; e_ov = 0; e_done = 0;
        e_rnd = 0; e_cnt = -1;
        case (ph)
            PH_IDLE:  e_crst = 1;
            PH_LOAD:  begin
                e_rdy = 1; e_wr = in_valid; e_inc = in_valid;
                e_crst = in_valid && (m_loaded == 63); e_cnt = m_loaded;
            end
            PH_ROUND: begin
                e_stg = !stall; e_inc = !stall;
                e_crst = !stall && (m_steps % 64 == 63);
                e_rnd = m_steps / 64; e_cnt = m_steps % 64;
            end
            PH_OUT:   begin
                e_ov = 1; e_inc = out_ready;
                e_crst = out_ready && (m_sent == 63); e_cnt = m_sent;
            end
            default:  begin e_done = 1; e_crst = 1; end
        endcase
        if (abort_hit()) begin
            e_crst = 1; e_inc = 0; e_done = 0;
        end
        check("in_ready", in_ready, e_rdy);
        check("lane_wr_en", lane_wr_en, e_wr);
        check("counter_rst", counter_rst, e_crst);
        check("inc_counter", inc_counter, e_inc);
        check("stage_en", stage_en, e_stg);
        check("out_valid", out_valid, e_ov);
        check("done", done, e_done);
        check("busy", busy, m_active);
        check("round_idx", round_idx, e_rnd);
        if (e_cnt >= 0) check("lane_count", cnt, e_cnt);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_outputs();
        end
    end

    // Per-test stimulus as a function of cycle offset from the start request.
    task automatic drive(input int test, input int rel);
        start     = (rel == 0) || (test == 5);
        in_valid  = (test == 2) ? (rel % 2 == 0) : 1'b1;
        stall     = (test == 3) && (rel >= 95) && (rel <= 104);
        out_ready = !((test == 4) && (rel >= 256) && (rel <= 260));
        abort     = (test == 6) && (rel == 146);
    endtask

    task automatic run_job(input int test, input int budget, output int lat, output int wr);
        lat = -1;
        wr  = 0;
        for (int rel = 0; rel < budget; rel++) begin
            @(posedge clk); #1;
            drive(test, rel);
            @(negedge clk);
            if (lane_wr_en) wr++;
            if (test == 1 && rel == 128) check("t1_round0_end", round_idx, 0);
            if (test == 1 && rel == 129) check("t1_round1", round_idx, 1);
            if (test == 1 && rel == 193) check("t1_out_round", round_idx, 0);
            if (test == 2 && rel == 128) check("t2_last_load", in_ready, 1);
            if (test == 2 && rel == 129) begin
                check("t2_round_entry_cnt", cnt, 0);
                check("t2_round_entry_stg", stage_en, 1);
            end
            if (test == 3 && rel == 100) begin
                check("t3_stall_cnt", cnt, 30);
                check("t3_stall_stg", stage_en, 0);
                check("t3_stall_rnd", round_idx, 0);
            end
            if (test == 4 && rel == 258) begin
                check("t4_hold_valid", out_valid, 1);
                check("t4_hold_inc", inc_counter, 0);
                check("t4_hold_cnt", cnt, 63);
            end
            if (test == 6 && rel == 147) begin
                check("t6_abort_busy", busy, 0);
                check("t6_abort_crst", counter_rst, 1);
                check("t6_abort_rnd", round_idx, 0);
            end
            if (done) begin
                lat = rel;
                break;
            end
        end
    endtask

    initial begin
        int lat, wr, ndone;
        repeat (2) @(negedge clk);
        check("rst_counter_rst", counter_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_round_idx", round_idx, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);

        run_job(1, 600, lat, wr);
        check("t1_latency", lat, 257);
        check("t1_lane_writes", wr, 64);

        run_job(2, 600, lat, wr);
        check("t2_latency", lat, 321);
        check("t2_lane_writes", wr, 64);

        run_job(3, 600, lat, wr);
        check("t3_latency", lat, 267);

        run_job(4, 600, lat, wr);
        check("t4_latency", lat, 262);

        run_job(5, 600, lat, wr);
        check("t5_latency", lat, 257);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_idle_before_restart", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t5_restart_load", in_ready, 1);
        repeat (141) @(posedge clk);
        @(negedge clk);
        check("t5_pre_rst_round", round_idx, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_round", round_idx, 0);
        check("t5_rst_crst", counter_rst, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t5_no_done_after_rst", ndone, 0);

`ifdef ROUND_CTRL_ABORT_EN
        run_job(6, 400, lat, wr);
        check("t6_no_done", lat, -1);
        run_job(1, 600, lat, wr);
        check("t6_rerun_latency", lat, 257);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
